// File: rtl/dmem_access_ctrl_pkg.sv
// Shared definitions for the data-memory access path: state encoding and default bus widths.
// The CPU and cache blocks import the same encodings.
package dmem_access_ctrl_pkg;

  localparam int unsigned DefDataW = 8;
  localparam int unsigned DefAddrW = 8;

  typedef logic [1:0] state_t;

  localparam state_t StIdle  = 2'b00;
  localparam state_t StRdReq = 2'b01;
  localparam state_t StWrReq = 2'b10;
  localparam state_t StDone  = 2'b11;

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// CPU-side and memory-side signals of the data-memory controller.
// slave: the controller itself; master: the CPU/memory environment around it.
interface dmem_access_ctrl_if #(
  parameter int unsigned DATA_W = dmem_access_ctrl_pkg::DefDataW,
  parameter int unsigned ADDR_W = dmem_access_ctrl_pkg::DefAddrW
);

  logic              READ;
  logic              WRITE;
  logic [ADDR_W-1:0] ADDRESS;
  logic [DATA_W-1:0] WRITEDATA;
  logic              BUSYWAIT;
  logic [DATA_W-1:0] READDATA;
  logic              ERR;
  logic              MEM_READ;
  logic              MEM_WRITE;
  logic [ADDR_W-1:0] MEM_ADDRESS;
  logic [DATA_W-1:0] MEM_WRITEDATA;
  logic [DATA_W-1:0] MEM_READDATA;
  logic              MEM_BUSYWAIT;

  modport slave (
    input  READ, WRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
    output BUSYWAIT, READDATA, ERR, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
  );

  modport master (
    output READ, WRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
    input  BUSYWAIT, READDATA, ERR, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
  );

endinterface

// File: rtl/dmem_access_ctrl_wait_timer.sv
// 8-bit wait counter for the request states; tc_o flags the edge at which the
// count would reach MaxWait, so a request state lasts at most MaxWait cycles.
module dmem_access_ctrl_wait_timer #(
  parameter int unsigned MaxWait = 15
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       en_i,
  output logic [7:0] cnt_o,
  output logic       tc_o
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 8'd0;
    end else if (en_i) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = en_i && (({1'b0, cnt_q} + 9'd1) == 9'(MaxWait));

endmodule

// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: turns CPU load/store requests into a registered
// memory read/write handshake, stalling the CPU through BUSYWAIT until completion.
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned ADDR_W   = DefAddrW,
  parameter int unsigned MAX_WAIT = 15
) (
  input logic               CLK,
  input logic               RESET,
  dmem_access_ctrl_if.slave bus
);

  state_t            state_q, state_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic       in_req;
  logic       first_cycle;
  logic       timer_tc;
  logic [7:0] timer_cnt;

  assign in_req = (state_q == StRdReq) || (state_q == StWrReq);

  dmem_access_ctrl_wait_timer #(
    .MaxWait(MAX_WAIT)
  ) u_wait_timer (
    .clk_i(CLK),
    .rst_i(RESET),
    .clr_i(!in_req),
    .en_i (in_req),
    .cnt_o(timer_cnt),
    .tc_o (timer_tc)
  );

  // Memory busy is not trusted until it has had one cycle to respond to the strobe.
  assign first_cycle = (timer_cnt == 8'd0);

  always_comb begin
    state_d     = state_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    err_d       = err_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    case (state_q)
      StIdle: begin
        if (bus.READ) begin
          addr_d     = bus.ADDRESS;
          mem_read_d = 1'b1;
          state_d    = StRdReq;
          if (bus.WRITE) err_d = 1'b1;
        end else if (bus.WRITE) begin
          addr_d      = bus.ADDRESS;
          wdata_d     = bus.WRITEDATA;
          mem_write_d = 1'b1;
          state_d     = StWrReq;
        end
      end
      StRdReq, StWrReq: begin
        if (!first_cycle && !bus.MEM_BUSYWAIT) begin
          if (state_q == StRdReq) rdata_d = bus.MEM_READDATA;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          state_d     = StDone;
        end else if (timer_tc) begin
          if (state_q == StRdReq) rdata_d = '1;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          err_d       = 1'b1;
          state_d     = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= StIdle;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      err_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      err_q       <= err_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  assign bus.BUSYWAIT      = ((state_q == StIdle) && (bus.READ || bus.WRITE)) || in_req;
  assign bus.READDATA      = rdata_q;
  assign bus.ERR           = err_q;
  assign bus.MEM_READ      = mem_read_q;
  assign bus.MEM_WRITE     = mem_write_q;
  assign bus.MEM_ADDRESS   = addr_q;
  assign bus.MEM_WRITEDATA = wdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: a latency-programmable memory model,
// a vector table of requests with a scoreboard queue, and hand-written reset/abort sequences.
module tb_dmem_access_ctrl;

  localparam int unsigned MaxWait = 15;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  dmem_access_ctrl_if #(.DATA_W(8), .ADDR_W(8)) bus ();

  dmem_access_ctrl #(
    .DATA_W  (8),
    .ADDR_W  (8),
    .MAX_WAIT(MaxWait)
  ) dut (
    .CLK  (clk),
    .RESET(rst),
    .bus  (bus)
  );

  // Memory model: busy for mem_lat cycles after a strobe rises; data = address ^ 8'hB7.
  int mem_lat = 0;
  int mem_cnt = 0;

  always @(posedge clk) begin
    if (bus.MEM_READ || bus.MEM_WRITE) mem_cnt <= mem_cnt + 1;
    else mem_cnt <= 0;
  end

  assign bus.MEM_BUSYWAIT = (bus.MEM_READ || bus.MEM_WRITE) && (mem_cnt < mem_lat);
  assign bus.MEM_READDATA = bus.MEM_ADDRESS ^ 8'hB7;

  typedef struct {
    logic       rd;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         lat;
    logic [7:0] exp_rdata;
    logic       exp_err;
    int         exp_cyc;
  } vec_t;

  vec_t sb[$];
  vec_t vecs[9];
  vec_t tmp;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic do_req(input vec_t v, input bit hold);
    vec_t e;
    int   cyc = 0;
    bit   saw_r = 0, saw_w = 0, addr_bad = 0, wd_bad = 0, done = 0;
    mem_lat       = v.lat;
    bus.READ      = v.rd;
    bus.WRITE     = v.wr;
    bus.ADDRESS   = v.addr;
    bus.WRITEDATA = v.wdata;
    sb.push_back(v);
    #1;
    chk("busy_on_request", 32'(bus.BUSYWAIT), 32'd1);
    for (int i = 0; i < 64 && !done; i++) begin
      @(posedge clk);
      #1;
      if (!bus.BUSYWAIT) begin
        done = 1;
      end else begin
        if (bus.MEM_READ || bus.MEM_WRITE) cyc++;
        saw_r |= bus.MEM_READ;
        saw_w |= bus.MEM_WRITE;
        if (bus.MEM_ADDRESS !== v.addr) addr_bad = 1;
        if (bus.MEM_WRITE && bus.MEM_WRITEDATA !== v.wdata) wd_bad = 1;
      end
    end
    chk("done_reached", 32'(done), 32'd1);
    e = sb.pop_front();
    chk("readdata", 32'(bus.READDATA), 32'(e.exp_rdata));
    chk("err", 32'(bus.ERR), 32'(e.exp_err));
    chk("strobe_cycles", 32'(cyc), 32'(e.exp_cyc));
    chk("saw_mem_read", 32'(saw_r), 32'(e.rd));
    chk("saw_mem_write", 32'(saw_w), 32'(e.wr && !e.rd));
    chk("mem_address", 32'(addr_bad), 32'd0);
    chk("mem_writedata", 32'(wd_bad), 32'd0);
    chk("strobe_in_done", 32'(bus.MEM_READ || bus.MEM_WRITE), 32'd0);
    if (hold) begin
      // Request still asserted through DONE must not start a new access at that edge.
      @(posedge clk);
      #1;
      chk("done_ignores_req", 32'(bus.MEM_READ || bus.MEM_WRITE), 32'd0);
      chk("idle_busy_with_req", 32'(bus.BUSYWAIT), 32'd1);
    end
    bus.READ  = 1'b0;
    bus.WRITE = 1'b0;
    #1;
    chk("busy_drop", 32'(bus.BUSYWAIT), 32'd0);
    @(posedge clk);
    #1;
    chk("idle_after", 32'(bus.BUSYWAIT || bus.MEM_READ || bus.MEM_WRITE), 32'd0);
  endtask

  initial begin
    rst           = 1'b1;
    bus.READ      = 1'b0;
    bus.WRITE     = 1'b0;
    bus.ADDRESS   = 8'h00;
    bus.WRITEDATA = 8'h00;

    vecs[0] = '{1'b1, 1'b0, 8'h12, 8'h00,  5, 8'hA5, 1'b0,  6};
    vecs[1] = '{1'b0, 1'b1, 8'h34, 8'h5A,  5, 8'hA5, 1'b0,  6};
    vecs[2] = '{1'b1, 1'b0, 8'h00, 8'h00,  0, 8'hB7, 1'b0,  2};
    vecs[3] = '{1'b1, 1'b0, 8'hFF, 8'h00,  1, 8'h48, 1'b0,  2};
    vecs[4] = '{1'b0, 1'b1, 8'h80, 8'hC3, 14, 8'h48, 1'b0, 15};
    vecs[5] = '{1'b1, 1'b0, 8'h55, 8'h00, 14, 8'hE2, 1'b0, 15};
    vecs[6] = '{1'b1, 1'b1, 8'h40, 8'h99,  2, 8'hF7, 1'b1,  3};
    vecs[7] = '{1'b1, 1'b0, 8'h66, 8'h00, 15, 8'hFF, 1'b1, 15};
    vecs[8] = '{1'b0, 1'b1, 8'h77, 8'h11, 20, 8'hFF, 1'b1, 15};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("idle_busywait", 32'(bus.BUSYWAIT), 32'd0);
    end
    chk("reset_readdata", 32'(bus.READDATA), 32'd0);
    chk("reset_err", 32'(bus.ERR), 32'd0);
    chk("reset_mem_read", 32'(bus.MEM_READ), 32'd0);
    chk("reset_mem_write", 32'(bus.MEM_WRITE), 32'd0);
    chk("reset_mem_address", 32'(bus.MEM_ADDRESS), 32'd0);
    chk("reset_mem_writedata", 32'(bus.MEM_WRITEDATA), 32'd0);

    for (int i = 0; i < 9; i++) do_req(vecs[i], 1'b0);

    // Reset during the third RD_REQ cycle abandons the access.
    mem_lat     = 10;
    bus.READ    = 1'b1;
    bus.ADDRESS = 8'h21;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("pre_reset_strobe", 32'(bus.MEM_READ), 32'd1);
    rst      = 1'b1;
    bus.READ = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_mid_strobe", 32'(bus.MEM_READ), 32'd0);
    chk("reset_mid_busy", 32'(bus.BUSYWAIT), 32'd0);
    chk("reset_mid_err", 32'(bus.ERR), 32'd0);
    chk("reset_mid_readdata", 32'(bus.READDATA), 32'd0);
    chk("reset_mid_address", 32'(bus.MEM_ADDRESS), 32'd0);
    @(posedge clk);
    #1;
    chk("reset_stays_idle", 32'(bus.MEM_READ || bus.BUSYWAIT), 32'd0);

    tmp = '{1'b1, 1'b0, 8'h01, 8'h00, 3, 8'hB6, 1'b0, 4};
    do_req(tmp, 1'b1);

    // Timeout from a clean error state raises ERR.
    tmp = '{1'b1, 1'b0, 8'h9A, 8'h00, 99, 8'hFF, 1'b1, 15};
    do_req(tmp, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
CPU-side controller for data memory in the 8-bit processor. It accepts load/store requests from the CPU and drives the data-memory read/write handshake. It stalls the CPU through BUSYWAIT until the memory completes. Its registered READDATA feeds the memory input of the register-file writeback 2:1 selector.

Parameters:
DATA_W, 8, data bus width
ADDR_W, 8, address bus width
MAX_WAIT, 15, max cycles in a request state before timeout abort (range 2..255)

Ports:
CLK  input  1  system clock, rising edge
RESET  input  1  synchronous, active-high reset
READ  input  1  CPU load request
WRITE  input  1  CPU store request
ADDRESS  input  ADDR_W  CPU address
WRITEDATA  input  DATA_W  CPU store data
BUSYWAIT  output  1  CPU stall (combinational)
READDATA  output  DATA_W  registered load result
ERR  output  1  sticky error flag (timeout or READ&WRITE together)
MEM_READ  output  1  memory read strobe (registered)
MEM_WRITE  output  1  memory write strobe (registered)
MEM_ADDRESS  output  ADDR_W  latched address
MEM_WRITEDATA  output  DATA_W  latched store data
MEM_READDATA  input  DATA_W  memory read data
MEM_BUSYWAIT  input  1  memory busy

Behaviour:
- Reset is synchronous, active-high, and applied at the CLK rising edge. On reset: state=IDLE; MEM_READ=MEM_WRITE=0; MEM_ADDRESS=MEM_WRITEDATA=0; READDATA=0; ERR=0; wait counter=0. Reset mid-request abandons the access; strobes drop at the same edge.
- States: IDLE, RD_REQ, WR_REQ, DONE.
- BUSYWAIT = (IDLE & (READ|WRITE)) | RD_REQ | WR_REQ. It is 0 in DONE, so the CPU stalls from the same cycle it raises a request.
- IDLE: at the edge with READ=1, latch ADDRESS, go RD_REQ, MEM_READ<=1. With WRITE=1 (READ=0), latch ADDRESS/WRITEDATA, go WR_REQ, MEM_WRITE<=1. READ&WRITE together: READ wins and ERR<=1.
- RD_REQ/WR_REQ: the counter increments each cycle. MEM_BUSYWAIT is ignored on the first cycle of the state, to absorb memory response latency.
  - From the 2nd cycle, MEM_BUSYWAIT=0 at an edge completes the access. For a read, READDATA<=MEM_READDATA. Strobe<=0, go DONE.
  - If the counter reaches MAX_WAIT with MEM_BUSYWAIT still 1: abort, strobe<=0, ERR<=1, READDATA<=all-ones for a read, go DONE.
- DONE: lasts 1 cycle, then IDLE. READ/WRITE during DONE are ignored, because the CPU advances on this edge. READDATA holds until the next completed or aborted read.
- A store never changes READDATA. MEM_ADDRESS/MEM_WRITEDATA hold their values between requests.
- Minimum request-to-DONE latency is 2 cycles in the request state plus 1 cycle in DONE. Back-to-back requests are separated by at least one IDLE cycle.
- ERR is cleared only by RESET.

Decomposition:
- Shared package: state encoding constants (IDLE=2'b00, RD_REQ=2'b01, WR_REQ=2'b10, DONE=2'b11) and the DATA_W/ADDR_W defaults; the CPU and cache blocks reuse these.
- One sub-module, wait_timer: an 8-bit counter with clear, enable, and a terminal-count output compared against MAX_WAIT.

Test Plan:
1. Reset, then idle 3 cycles -> all outputs 0, BUSYWAIT=0.
2. Read ADDRESS=8'h12, memory model busy 5 cycles returning 8'hA5 -> MEM_READ high for the request duration, MEM_ADDRESS=8'h12, READDATA=8'hA5 in DONE, BUSYWAIT falls in DONE.
3. Write ADDRESS=8'h34, WRITEDATA=8'h5A, memory busy 5 cycles -> MEM_WRITE high, MEM_WRITEDATA=8'h5A, READDATA unchanged, ERR=0.
4. Read with MEM_BUSYWAIT stuck at 1 -> abort after MAX_WAIT=15 cycles, READDATA=8'hFF, ERR=1, return to IDLE.
5. READ=WRITE=1 at 8'h40 -> read performed, no MEM_WRITE pulse, ERR=1.
6. RESET asserted on the 3rd cycle of RD_REQ -> MEM_READ=0 and state IDLE after that edge; a following read at 8'h01 completes normally.
